// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit producing MIPS-style HI/LO.
// Define DIV_ZERO_EXC_EN to short-circuit divide-by-zero into an immediate done with div_zero set.
module mult_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_zero
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

  state_t                   state;
  logic [4:0]               cnt;
  logic signed [DATA_W:0]   acc;
  logic [DATA_W-1:0]        q_reg;
  logic                     q_m1;
  logic [DATA_W-1:0]        m_reg;
  logic                     sign_q;
  logic                     sign_r;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Booth step: add/subtract multiplicand by {Q[0], Q[-1]}, then arithmetic shift {A,Q,Q[-1]} right.
  logic signed [DATA_W:0] m_ext;
  logic signed [DATA_W:0] booth_sum;
  logic signed [DATA_W:0] booth_acc;
  logic [DATA_W-1:0]      booth_q;

  assign m_ext = {m_reg[DATA_W-1], m_reg};

  always_comb begin
    booth_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  assign booth_acc = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
  assign booth_q   = {booth_sum[0], q_reg[DATA_W-1:1]};

  // Restoring step on magnitudes; the remainder never exceeds 2^31 so bit 33 of the trial is its sign.
  logic [DATA_W+1:0]  div_shift;
  logic [DATA_W+1:0]  div_trial;
  logic               div_qbit;
  logic [DATA_W:0]    div_rem;
  logic [DATA_W-1:0]  div_q;

  assign div_shift = {acc, q_reg[DATA_W-1]};
  assign div_trial = div_shift - {2'b00, m_reg};
  assign div_qbit  = ~div_trial[DATA_W+1];
  assign div_rem   = div_qbit ? div_trial[DATA_W:0] : div_shift[DATA_W:0];
  assign div_q     = {q_reg[DATA_W-2:0], div_qbit};

`ifdef DIV_ZERO_EXC_EN
  logic dz_q;
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      m_reg  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
`ifdef DIV_ZERO_EXC_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
          dz_q <= 1'b0;
`endif
          if (start_mult) begin
            state <= MULT;
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= '0;
            q_reg <= op_b;
            q_m1  <= 1'b0;
            m_reg <= op_a;
          end else if (start_div) begin
`ifdef DIV_ZERO_EXC_EN
            if (op_b == '0) begin
              state <= FIN;
              done  <= 1'b1;
              dz_q  <= 1'b1;
            end else
`endif
            begin
              state  <= DIV;
              busy   <= 1'b1;
              cnt    <= '0;
              acc    <= '0;
              q_reg  <= abs_val(op_a);
              m_reg  <= abs_val(op_b);
              sign_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
              sign_r <= op_a[DATA_W-1];
            end
          end
        end
        MULT: begin
          acc   <= booth_acc;
          q_reg <= booth_q;
          q_m1  <= q_reg[0];
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi_out <= booth_acc[DATA_W-1:0];
            lo_out <= booth_q;
          end
        end
        DIV: begin
          acc   <= div_rem;
          q_reg <= div_q;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi_out <= neg_if(div_rem[DATA_W-1:0], sign_r);
            lo_out <= neg_if(div_q, sign_q);
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
          dz_q  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed-vector bench for mult_div_ctrl: table of multiply/divide results plus
// hand-written sequences for start collisions, mid-operation reset and divide by zero.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_zero;

  mult_div_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge of an IDLE cycle (T); returns at the negedge of T+34.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    logic early;
    op_a       = a;
    op_b       = b;
    start_mult = !is_div;
    start_div  = is_div;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    check({nm, "_busy_t1"}, {31'd0, busy}, 32'd1);
    early = 1'b0;
    for (int k = 2; k <= 32; k++) begin
      @(negedge clk);
      if (done) early = 1'b1;
      if (k == 32) begin
        check({nm, "_busy_t32"}, {31'd0, busy}, 32'd1);
        check({nm, "_hi_hold"}, hi_out, prev_hi);
        check({nm, "_lo_hold"}, lo_out, prev_lo);
      end
    end
    check({nm, "_early_done"}, {31'd0, early}, 32'd0);
    @(negedge clk);
    check({nm, "_done_t33"}, {31'd0, done}, 32'd1);
    check({nm, "_busy_t33"}, {31'd0, busy}, 32'd0);
    check({nm, "_hi"}, hi_out, exp_hi);
    check({nm, "_lo"}, lo_out, exp_lo);
    check({nm, "_dz"}, {31'd0, div_zero}, 32'd0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
    @(negedge clk);
    check({nm, "_done_t34"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[4]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[8]  = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[9]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back operations: each starts in the IDLE cycle right after FIN.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Simultaneous starts (multiply wins), plus ignored starts at T+5 and T+33.
    op_a       = 32'h0000_0007;
    op_b       = 32'hFFFF_FFFD;
    start_mult = 1'b1;
    start_div  = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_mult = 1'b0;
        start_div  = 1'b0;
      end
      if (k == 5) begin
        start_div = 1'b1;
        op_a      = 32'h0000_0064;
        op_b      = 32'h0000_0007;
      end
      if (k == 6) start_div = 1'b0;
      if (k == 33) begin
        check("both_done", {31'd0, done}, 32'd1);
        check("both_hi", hi_out, 32'hFFFF_FFFF);
        check("both_lo", lo_out, 32'hFFFF_FFEB);
        start_mult = 1'b1;
        op_a       = 32'h0000_0003;
        op_b       = 32'h0000_0003;
      end
      if (k == 34) begin
        start_mult = 1'b0;
        check("both_busy_t34", {31'd0, busy}, 32'd0);
        check("both_done_t34", {31'd0, done}, 32'd0);
      end
    end
    @(negedge clk);
    check("both_busy_t35", {31'd0, busy}, 32'd0);
    check("both_lo_t35", lo_out, 32'hFFFF_FFEB);
    prev_hi = 32'hFFFF_FFFF;
    prev_lo = 32'hFFFF_FFEB;

    // Reset at T+10 of a multiply.
    op_a       = 32'h0000_0005;
    op_b       = 32'h0000_0006;
    start_mult = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start_mult = 1'b0;
      if (k == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi_out, 32'd0);
    check("abort_lo", lo_out, 32'd0);
    check("abort_dz", {31'd0, div_zero}, 32'd0);
    prev_hi = '0;
    prev_lo = '0;
    run_op(1'b0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, "post_rst");

`ifdef DIV_ZERO_EXC_EN
    op_a      = 32'h0000_0005;
    op_b      = 32'h0000_0000;
    start_div = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    check("dz_done_t1", {31'd0, done}, 32'd1);
    check("dz_flag_t1", {31'd0, div_zero}, 32'd1);
    check("dz_busy_t1", {31'd0, busy}, 32'd0);
    check("dz_hi", hi_out, prev_hi);
    check("dz_lo", lo_out, prev_lo);
    @(negedge clk);
    check("dz_done_t2", {31'd0, done}, 32'd0);
    check("dz_flag_t2", {31'd0, div_zero}, 32'd0);
    check("dz_busy_t2", {31'd0, busy}, 32'd0);
`else
    run_op(1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "dz_pos");
    run_op(1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001, "dz_neg");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start_mult, input, 1 bit: request a signed multiply of op_a by op_b, sampled in IDLE.
REQ-005 The block SHALL have port start_div, input, 1 bit: request a signed divide of op_a by op_b, sampled in IDLE.
REQ-006 The block SHALL have port op_a, input, 32 bits: multiplicand or dividend (register rs).
REQ-007 The block SHALL have port op_b, input, 32 bits: multiplier or divisor (register rt).
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is iterating.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port hi_out, output, 32 bits: the HI result value.
REQ-011 The block SHALL have port lo_out, output, 32 bits: the LO result value.
REQ-012 The block SHALL have port div_zero, output, 1 bit: divide-by-zero flag, valid with done.

Function
REQ-013 The block SHALL use the states IDLE, MULT, DIV and FIN.
REQ-014 IDLE SHALL transition to MULT on start_mult, or to DIV on start_div, latching op_a and op_b in the sampling cycle T.
REQ-015 If start_mult and start_div are both high in IDLE, multiply SHALL win and the divide request SHALL be dropped.
REQ-016 Start requests SHALL be ignored in MULT, DIV and FIN; operands SHALL NOT be re-sampled mid-operation.
REQ-017 MULT SHALL perform radix-2 Booth signed multiplication with one iteration per cycle for 32 cycles (T+1..T+32), and then go to FIN.
REQ-018 DIV SHALL perform restoring division on operand magnitudes with one iteration per cycle for 32 cycles (T+1..T+32), and then go to FIN.
REQ-019 A divide result SHALL have the quotient truncated toward zero and the remainder taking the sign of the dividend.
REQ-020 A multiply SHALL load HI with product[63:32] and LO with product[31:0]; a divide SHALL load LO with the quotient and HI with the remainder.
REQ-021 0x80000000 divided by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000 with no flag raised.
REQ-022 FIN SHALL last exactly one cycle (T+33) with done=1 and hi_out/lo_out already updated in that cycle, and SHALL always transition to IDLE next.
REQ-023 busy SHALL be 1 exactly in MULT and DIV, and 0 in IDLE and FIN.
REQ-024 hi_out and lo_out SHALL change only on entry to FIN and SHALL hold their values at all other times (iteration uses separate internal accumulators).
REQ-025 A new start SHALL be accepted in the IDLE cycle immediately after FIN.
REQ-026 div_zero SHALL be 0 except as defined under Configuration.

Reset
REQ-027 On reset=1 at a clock edge, the state SHALL go to IDLE and hi_out, lo_out, busy, done and div_zero SHALL all be 0, together with the counter and the accumulators.
REQ-028 Reset during MULT or DIV SHALL abort the operation with no done pulse and no HI/LO update other than clearing.
REQ-029 Reset SHALL take precedence over a start request in the same cycle.

Configuration
REQ-030 The macro DIV_ZERO_EXC_EN SHALL control divide-by-zero handling.
REQ-031 With DIV_ZERO_EXC_EN defined, a start_div with op_b=0 SHALL go from IDLE directly to FIN, with done=1 and div_zero=1 at T+1, busy never asserted, and hi_out/lo_out unchanged.
REQ-032 Without DIV_ZERO_EXC_EN, div_zero SHALL be tied to 0, and a divide by zero SHALL run all 32 iterations, finishing with HI=op_a and LO=0xFFFFFFFF if op_a>=0, else LO=0x00000001.

Verification
REQ-033 Scenario: start_mult, op_a=7, op_b=0xFFFFFFFD -> busy high from T+1 to T+32; at T+33 done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 Scenario: start_mult, op_a=op_b=0x80000000 -> at T+33 HI=0x40000000, LO=0x00000000.
REQ-035 Scenario: start_div, op_a=0xFFFFFFF9 (-7), op_b=2 -> at T+33 LO=0xFFFFFFFD, HI=0xFFFFFFFF; then 0x80000000 divided by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 Scenario: with the macro, start_div op_b=0 after a prior result -> done=1 and div_zero=1 at T+1, HI/LO equal the prior result; without the macro, op_a=5 -> at T+33 HI=5, LO=0xFFFFFFFF, div_zero=0.
REQ-037 Scenario: start_mult and start_div both high in one IDLE cycle, plus extra start pulses at T+5 and at T+33 -> a single multiply result at T+33 and no second operation.
REQ-038 Scenario: reset asserted at T+10 of a multiply -> from T+11 all outputs are 0, no done pulse ever appears, and a fresh start_mult is accepted immediately afterwards.
